arm_multicycle_controller: RTL and testbench

Multi-cycle control unit for the ARM datapath. It shares one ALU and one unified instruction/data memory across the steps of each instruction by sequencing them through a Moore state machine. It decodes the 16-bit instruction word held in the datapath instruction register, keeps the NZCV flags, and evaluates condition codes. It also stretches memory states with a request/ready handshake.

---
 rtl/arm_multicycle_pkg.sv | 71 +++++++
 rtl/arm_multicycle_cond_check.sv | 39 +++
 rtl/arm_multicycle_controller.sv | 207 ++++++++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_multicycle_pkg.sv
// Shared definitions for the ARM multi-cycle controller.
// Contents: FSM state enum, instruction op enum, data-processing command
// codes, condition-code enum, datapath select encodings, and decode helpers.
package arm_multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        OP_DP    = 2'b00,
        OP_MEM   = 2'b01,
        OP_BR    = 2'b10,
        OP_UNDEF = 2'b11
    } op_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_LO = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // True for the data-processing commands this controller implements.
    function automatic logic cmd_valid(input logic [3:0] cmd);
        case (cmd)
            CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR: cmd_valid = 1'b1;
            default:                                     cmd_valid = 1'b0;
        endcase
    endfunction

    // ALU operation for a command; CMP is a subtract whose result is dropped.
    function automatic logic [1:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: cmd_alu = ALU_SUB;
            CMD_AND:          cmd_alu = ALU_AND;
            CMD_ORR:          cmd_alu = ALU_ORR;
            default:          cmd_alu = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/arm_multicycle_cond_check.sv
// Condition-code evaluator (combinational).
// Ports: cond   - instruction condition field
//        flags  - architectural {N,Z,C,V}
//        cond_ex - 1 when the instruction should execute
module arm_multicycle_cond_check
    import arm_multicycle_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n_s, z_s, c_s, v_s;
    assign {n_s, z_s, c_s, v_s} = flags;

    // Standard ARM condition evaluation; the 1111 encoding never executes.
    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_ex = z_s;
            COND_NE: cond_ex = ~z_s;
            COND_CS: cond_ex = c_s;
            COND_LO: cond_ex = ~c_s;
            COND_MI: cond_ex = n_s;
            COND_PL: cond_ex = ~n_s;
            COND_VS: cond_ex = v_s;
            COND_VC: cond_ex = ~v_s;
            COND_HI: cond_ex = c_s & ~z_s;
            COND_LS: cond_ex = ~c_s | z_s;
            COND_GE: cond_ex = ~(n_s ^ v_s);
            COND_LT: cond_ex = n_s ^ v_s;
            COND_GT: cond_ex = ~z_s & ~(n_s ^ v_s);
            COND_LE: cond_ex = z_s | (n_s ^ v_s);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_multicycle_controller.sv
// Multi-cycle ARM control unit: sequences each instruction through a Moore
// FSM sharing one ALU and one unified memory, holds the NZCV flags, and
// stretches memory states until i_Mem_Ready.
// Inputs : i_CLK, i_RESET_N (async, active low), i_Instr (IR contents),
//          i_ALU_Flags {N,Z,C,V}, i_Mem_Ready.
// Outputs: memory controls (o_Mem_Req, o_Mem_Write, o_Adr_Src), register
//          strobes (o_IR_Write, o_PC_Write, o_Reg_Write), datapath selects
//          (o_ALU_SrcA/B, o_Result_Src, o_Imm_Src, o_Reg_Src, o_ALU_Control),
//          and o_Undef (one-cycle pulse when an undefined instruction is dropped).
module arm_multicycle_controller
    import arm_multicycle_pkg::*;
(
    input  logic        i_CLK,
    input  logic        i_RESET_N,
    input  logic [15:0] i_Instr,
    input  logic [3:0]  i_ALU_Flags,
    input  logic        i_Mem_Ready,
    output logic        o_Mem_Req,
    output logic        o_Mem_Write,
    output logic        o_Adr_Src,
    output logic        o_IR_Write,
    output logic        o_PC_Write,
    output logic        o_Reg_Write,
    output logic        o_ALU_SrcA,
    output logic [1:0]  o_ALU_SrcB,
    output logic [1:0]  o_Result_Src,
    output logic [1:0]  o_Imm_Src,
    output logic [1:0]  o_Reg_Src,
    output logic [1:0]  o_ALU_Control,
    output logic        o_Undef
);

    logic [3:0] cond_s;
    op_t        op_s;
    logic       imm_s;
    logic [3:0] cmd_s;
    logic       sbit_s;
    logic       rd_pc_s;
    logic       cond_ex_s;
    logic       undef_s;

    state_t     state_r, state_next_s;
    logic [3:0] flags_r, flags_next_s;

    assign cond_s  = i_Instr[15:12];
    assign op_s    = op_t'(i_Instr[11:10]);
    assign imm_s   = i_Instr[9];
    assign cmd_s   = i_Instr[8:5];
    assign sbit_s  = i_Instr[4];
    assign rd_pc_s = (i_Instr[3:0] == 4'd15);

    arm_multicycle_cond_check u_cond_check (
        .cond    (cond_s),
        .flags   (flags_r),
        .cond_ex (cond_ex_s)
    );

    // Undefined only matters once the condition has passed.
    assign undef_s = cond_ex_s &
                     ((op_s == OP_UNDEF) | ((op_s == OP_DP) & ~cmd_valid(cmd_s)));

    // Next-state and flag-update logic.
    always_comb begin
        state_next_s = state_r;
        flags_next_s = flags_r;
        case (state_r)
            S_IDLE:   state_next_s = S_FETCH;
            S_FETCH: begin
                if (i_Mem_Ready) state_next_s = S_DECODE;
                else             state_next_s = S_FETCH;
            end
            S_DECODE: begin
                if (!cond_ex_s || undef_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    case (op_s)
                        OP_DP:   state_next_s = imm_s ? S_EXECI : S_EXECR;
                        OP_MEM:  state_next_s = S_MEMADR;
                        OP_BR:   state_next_s = S_BRANCH;
                        default: state_next_s = S_FETCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                // Logical ops leave C and V untouched.
                if (sbit_s && (cmd_s == CMD_AND || cmd_s == CMD_ORR)) begin
                    flags_next_s = {i_ALU_Flags[3:2], flags_r[1:0]};
                end else if (sbit_s) begin
                    flags_next_s = i_ALU_Flags;
                end else begin
                    flags_next_s = flags_r;
                end
                if (cmd_s == CMD_CMP) state_next_s = S_FETCH;
                else                  state_next_s = S_ALUWB;
            end
            S_ALUWB:  state_next_s = S_FETCH;
            S_MEMADR: state_next_s = sbit_s ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (i_Mem_Ready) state_next_s = S_MEMWB;
                else             state_next_s = S_MEMREAD;
            end
            S_MEMWB:  state_next_s = S_FETCH;
            S_MEMWRITE: begin
                if (i_Mem_Ready) state_next_s = S_FETCH;
                else             state_next_s = S_MEMWRITE;
            end
            S_BRANCH: state_next_s = S_FETCH;
            default:  state_next_s = S_IDLE;
        endcase
    end

    // State-decoded outputs; only the FETCH strobes look at i_Mem_Ready.
    always_comb begin
        o_Mem_Req     = 1'b0;
        o_Mem_Write   = 1'b0;
        o_Adr_Src     = 1'b0;
        o_IR_Write    = 1'b0;
        o_PC_Write    = 1'b0;
        o_Reg_Write   = 1'b0;
        o_ALU_SrcA    = 1'b0;
        o_ALU_SrcB    = SRCB_REG;
        o_Result_Src  = RES_ALUOUT;
        o_Imm_Src     = 2'b00;
        o_Reg_Src     = 2'b00;
        o_ALU_Control = ALU_ADD;
        o_Undef       = 1'b0;
        case (state_r)
            S_FETCH: begin
                o_Mem_Req    = 1'b1;
                o_IR_Write   = i_Mem_Ready;
                o_PC_Write   = i_Mem_Ready;
                o_ALU_SrcA   = 1'b1;
                o_ALU_SrcB   = SRCB_FOUR;
                o_Result_Src = RES_ALU;
            end
            S_DECODE: begin
                // PC+4 again here gives PC+8 for R15 reads.
                o_ALU_SrcA   = 1'b1;
                o_ALU_SrcB   = SRCB_FOUR;
                o_Result_Src = RES_ALU;
                o_Undef      = undef_s;
                case (op_s)
                    OP_MEM: begin
                        o_Imm_Src = 2'b01;
                        o_Reg_Src = {~sbit_s, 1'b0};
                    end
                    OP_BR: begin
                        o_Imm_Src = 2'b10;
                        o_Reg_Src = 2'b01;
                    end
                    default: begin
                        o_Imm_Src = 2'b00;
                        o_Reg_Src = 2'b00;
                    end
                endcase
            end
            S_EXECR: o_ALU_Control = cmd_alu(cmd_s);
            S_EXECI: begin
                o_ALU_SrcB    = SRCB_IMM;
                o_ALU_Control = cmd_alu(cmd_s);
            end
            S_ALUWB: begin
                o_PC_Write  = rd_pc_s;
                o_Reg_Write = ~rd_pc_s;
            end
            S_MEMADR: begin
                o_ALU_SrcB = SRCB_IMM;
                o_Imm_Src  = 2'b01;
            end
            S_MEMREAD: begin
                o_Mem_Req = 1'b1;
                o_Adr_Src = 1'b1;
            end
            S_MEMWB: begin
                o_Result_Src = RES_DATA;
                o_PC_Write   = rd_pc_s;
                o_Reg_Write  = ~rd_pc_s;
            end
            S_MEMWRITE: begin
                o_Mem_Req   = 1'b1;
                o_Mem_Write = 1'b1;
                o_Adr_Src   = 1'b1;
                o_Reg_Src   = 2'b10;
            end
            S_BRANCH: begin
                o_ALU_SrcB   = SRCB_IMM;
                o_Imm_Src    = 2'b10;
                o_Reg_Src    = 2'b01;
                o_Result_Src = RES_ALU;
                o_PC_Write   = 1'b1;
            end
            default: o_Undef = 1'b0;
        endcase
    end

    // State and flags registers.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_r <= S_IDLE;
            flags_r <= 4'b0000;
        end else begin
            state_r <= state_next_s;
            flags_r <= flags_next_s;
        end
    end

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Self-checking bench for arm_multicycle_controller: a per-cycle vector
// table driven through a scoreboard queue, plus a reset-mid-fetch sequence.
module tb_arm_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic [3:0]  alu_flags;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_srca, undef;
    logic [1:0]  alu_srcb, result_src, imm_src, reg_src, alu_control;

    arm_multicycle_controller dut (
        .i_CLK         (clk),
        .i_RESET_N     (rst_n),
        .i_Instr       (instr),
        .i_ALU_Flags   (alu_flags),
        .i_Mem_Ready   (mem_ready),
        .o_Mem_Req     (mem_req),
        .o_Mem_Write   (mem_write),
        .o_Adr_Src     (adr_src),
        .o_IR_Write    (ir_write),
        .o_PC_Write    (pc_write),
        .o_Reg_Write   (reg_write),
        .o_ALU_SrcA    (alu_srca),
        .o_ALU_SrcB    (alu_srcb),
        .o_Result_Src  (result_src),
        .o_Imm_Src     (imm_src),
        .o_Reg_Src     (reg_src),
        .o_ALU_Control (alu_control),
        .o_Undef       (undef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  flags;
        logic        ready;
        logic [17:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [17:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Output word: {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,
    //               srca,srcb,result_src,imm_src,reg_src,alu_control,undef}
    function automatic logic [17:0] mk(input logic mr, mw, as, irw, pcw, rw, sa,
                                       input logic [1:0] sbv, rs, is, rg, ac,
                                       input logic un);
        return {mr, mw, as, irw, pcw, rw, sa, sbv, rs, is, rg, ac, un};
    endfunction

    function automatic logic [17:0] e_fetch(input logic rdy);
        return mk(1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
    endfunction
    function automatic logic [17:0] e_dec(input logic [1:0] is, rg, input logic un);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, is, rg, 2'b00, un);
    endfunction
    function automatic logic [17:0] e_exec(input logic i, input logic [1:0] ac);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b0, i}, 2'b00, 2'b00, 2'b00, ac, 1'b0);
    endfunction
    function automatic logic [17:0] e_wb(input logic pc, input logic [1:0] rs);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, pc, ~pc, 1'b0, 2'b00, rs, 2'b00, 2'b00, 2'b00, 1'b0);
    endfunction

    logic [17:0] e_idle, e_madr, e_mrd, e_mwr, e_br;

    task automatic add(input logic [15:0] i, input logic [3:0] f, input logic r, input logic [17:0] e);
        vec_t v;
        v.instr = i; v.flags = f; v.ready = r; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check();
        logic [17:0] act, exp;
        act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_srca,
               alu_srcb, result_src, imm_src, reg_src, alu_control, undef};
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %05h, no expectation queued", act);
        end else begin
            exp = sb.pop_front();
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL vector %0d outputs: got %05h, expected %05h", n_vec, act, exp);
            end
        end
    endtask

    // Apply one cycle of stimulus at posedge+1, compare at the following negedge.
    task automatic run_vec(input vec_t v);
        instr = v.instr; alu_flags = v.flags; mem_ready = v.ready;
        sb.push_back(v.exp);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        e_idle = 18'h00000;
        e_madr = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        e_mrd  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        e_mwr  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
        e_br   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0);

        // IDLE after reset
        add(16'h0000, 4'h0, 1'b1, e_idle);
        // SUBS r1 (imm) producing Z, then BEQ taken
        add(16'hE251, 4'b0100, 1'b1, e_fetch(1'b1));
        add(16'hE251, 4'b0100, 1'b1, e_dec(2'b00, 2'b00, 1'b0));
        add(16'hE251, 4'b0100, 1'b1, e_exec(1'b1, 2'b01));
        add(16'hE251, 4'b0100, 1'b1, e_wb(1'b0, 2'b00));
        add(16'h0800, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'h0800, 4'b0000, 1'b1, e_dec(2'b10, 2'b01, 1'b0));
        add(16'h0800, 4'b0000, 1'b1, e_br);
        // SUBS clearing Z, then BEQ not taken
        add(16'hE251, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'hE251, 4'b0000, 1'b1, e_dec(2'b00, 2'b00, 1'b0));
        add(16'hE251, 4'b0000, 1'b1, e_exec(1'b1, 2'b01));
        add(16'hE251, 4'b0000, 1'b1, e_wb(1'b0, 2'b00));
        add(16'h0800, 4'b0100, 1'b1, e_fetch(1'b1));
        add(16'h0800, 4'b0100, 1'b1, e_dec(2'b10, 2'b01, 1'b0));
        // ADD r2 register form
        add(16'hE082, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'hE082, 4'b0000, 1'b1, e_dec(2'b00, 2'b00, 1'b0));
        add(16'hE082, 4'b0000, 1'b1, e_exec(1'b0, 2'b00));
        add(16'hE082, 4'b0000, 1'b1, e_wb(1'b0, 2'b00));
        // LDR with two wait cycles in FETCH and MEMREAD (9 cycles)
        add(16'hE413, 4'b0000, 1'b0, e_fetch(1'b0));
        add(16'hE413, 4'b0000, 1'b0, e_fetch(1'b0));
        add(16'hE413, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'hE413, 4'b0000, 1'b0, e_dec(2'b01, 2'b00, 1'b0));
        add(16'hE413, 4'b0000, 1'b0, e_madr);
        add(16'hE413, 4'b0000, 1'b0, e_mrd);
        add(16'hE413, 4'b0000, 1'b0, e_mrd);
        add(16'hE413, 4'b0000, 1'b1, e_mrd);
        add(16'hE413, 4'b0000, 1'b0, e_wb(1'b0, 2'b01));
        // STR held in MEMWRITE until ready
        add(16'hE400, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'hE400, 4'b0000, 1'b1, e_dec(2'b01, 2'b10, 1'b0));
        add(16'hE400, 4'b0000, 1'b1, e_madr);
        add(16'hE400, 4'b0000, 1'b0, e_mwr);
        add(16'hE400, 4'b0000, 1'b0, e_mwr);
        add(16'hE400, 4'b0000, 1'b1, e_mwr);
        // CMP sets Z, 3 cycles; BNE then fails
        add(16'hE150, 4'b0100, 1'b1, e_fetch(1'b1));
        add(16'hE150, 4'b0100, 1'b1, e_dec(2'b00, 2'b00, 1'b0));
        add(16'hE150, 4'b0100, 1'b1, e_exec(1'b0, 2'b01));
        add(16'h1800, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'h1800, 4'b0000, 1'b1, e_dec(2'b10, 2'b01, 1'b0));
        // op=11 and unsupported DP cmd: undef pulse, back to FETCH
        add(16'hEC00, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'hEC00, 4'b0000, 1'b1, e_dec(2'b00, 2'b00, 1'b1));
        add(16'hE020, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'hE020, 4'b0000, 1'b1, e_dec(2'b00, 2'b00, 1'b1));
        // ADD to r15 writes PC instead of the register file
        add(16'hE08F, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'hE08F, 4'b0000, 1'b1, e_dec(2'b00, 2'b00, 1'b0));
        add(16'hE08F, 4'b0000, 1'b1, e_exec(1'b0, 2'b00));
        add(16'hE08F, 4'b0000, 1'b1, e_wb(1'b1, 2'b00));
        // ORR immediate
        add(16'hE383, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'hE383, 4'b0000, 1'b1, e_dec(2'b00, 2'b00, 1'b0));
        add(16'hE383, 4'b0000, 1'b1, e_exec(1'b1, 2'b11));
        add(16'hE383, 4'b0000, 1'b1, e_wb(1'b0, 2'b00));
        // ANDS with ALU flags 1011: only N,Z load -> flags 1000
        add(16'hE012, 4'b1011, 1'b1, e_fetch(1'b1));
        add(16'hE012, 4'b1011, 1'b1, e_dec(2'b00, 2'b00, 1'b0));
        add(16'hE012, 4'b1011, 1'b1, e_exec(1'b0, 2'b10));
        add(16'hE012, 4'b1011, 1'b1, e_wb(1'b0, 2'b00));
        // BVS fails (V kept 0), BMI taken (N=1), cond 1111 fails
        add(16'h6800, 4'b1111, 1'b1, e_fetch(1'b1));
        add(16'h6800, 4'b1111, 1'b1, e_dec(2'b10, 2'b01, 1'b0));
        add(16'h4800, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'h4800, 4'b0000, 1'b1, e_dec(2'b10, 2'b01, 1'b0));
        add(16'h4800, 4'b0000, 1'b1, e_br);
        add(16'hF800, 4'b0000, 1'b1, e_fetch(1'b1));
        add(16'hF800, 4'b0000, 1'b1, e_dec(2'b10, 2'b01, 1'b0));
        // SUBS setting Z before the mid-fetch reset
        add(16'hE251, 4'b0100, 1'b1, e_fetch(1'b1));
        add(16'hE251, 4'b0100, 1'b1, e_dec(2'b00, 2'b00, 1'b0));
        add(16'hE251, 4'b0100, 1'b1, e_exec(1'b1, 2'b01));
        add(16'hE251, 4'b0100, 1'b1, e_wb(1'b0, 2'b00));

        rst_n = 1'b0; instr = 16'h0000; alu_flags = 4'h0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[k]) run_vec(tbl[k]);

        // Stalled FETCH, then asynchronous reset mid-access
        v.instr = 16'h0800; v.flags = 4'h0; v.ready = 1'b0; v.exp = e_fetch(1'b0);
        run_vec(v);
        rst_n = 1'b0;
        #2;
        sb.push_back(e_idle);
        check();
        @(posedge clk);
        #1;
        sb.push_back(e_idle);
        check();
        rst_n = 1'b1;
        // One IDLE cycle, then BEQ must not be taken (flags cleared)
        v.ready = 1'b1; v.exp = e_idle;                       run_vec(v);
        v.exp = e_fetch(1'b1);                                run_vec(v);
        v.exp = e_dec(2'b10, 2'b01, 1'b0);                    run_vec(v);
        v.ready = 1'b0; v.exp = e_fetch(1'b0);                run_vec(v);

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
